// File: rtl/nasti_stream_reader_if.sv
// NASTI memory channel and NASTI-stream channel bundles shared by the stream movers.
// Modports are named from the point of view of the block that drives the channel.

interface nasti_channel #(
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid;
    logic                    w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

interface nasti_stream_channel #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH = 1,
    parameter int unsigned USER_WIDTH = 1
);
    logic                    t_valid;
    logic                    t_ready;
    logic [DATA_WIDTH-1:0]   t_data;
    logic [DATA_WIDTH/8-1:0] t_strb;
    logic [DATA_WIDTH/8-1:0] t_keep;
    logic                    t_last;
    logic [ID_WIDTH-1:0]     t_id;
    logic [DEST_WIDTH-1:0]   t_dest;
    logic [USER_WIDTH-1:0]   t_user;

    modport master (
        output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        output t_ready
    );
endinterface

// File: rtl/nasti_stream_reader.sv
// Reads a block of aligned words over NASTI read bursts and emits it as one stream packet.
// One request and one AR burst in flight; R beats pass through a single registered output stage.

module nasti_stream_reader #(
    parameter int unsigned ADDR_WIDTH       = 64,
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned MAX_BURST_LENGTH = 8,
    parameter int unsigned LEN_WIDTH        = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    nasti_channel.master          src,
    nasti_stream_channel.master   dest,
    input  logic [ADDR_WIDTH-1:0] r_src,
    input  logic [LEN_WIDTH-1:0]  r_len,
    input  logic                  r_valid,
    output logic                  r_ready,
    output logic                  r_err
);

    localparam int unsigned ADDR_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int unsigned BEAT_WIDTH = $clog2(MAX_BURST_LENGTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~((ADDR_WIDTH'(1) << ADDR_SHIFT) - 1);

    // StDrain waits for the final (or null) beat to leave the output register.
    typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]   rem_q;
    logic [BEAT_WIDTH-1:0]  beats_q;
    logic [BEAT_WIDTH-1:0]  burst_n;
    logic [DATA_WIDTH-1:0]  t_data_q;
    logic                   t_valid_q, t_last_q, t_null_q, err_q;
    logic                   accept, ar_fire, r_fire, t_fire, last_beat;

    assign accept    = r_valid && (state_q == StIdle);
    assign ar_fire   = src.ar_valid && src.ar_ready;
    assign r_fire    = src.r_valid && src.r_ready;
    assign t_fire    = t_valid_q && dest.t_ready;
    assign last_beat = (beats_q == BEAT_WIDTH'(1));
    assign burst_n   = (rem_q < LEN_WIDTH'(MAX_BURST_LENGTH)) ? BEAT_WIDTH'(rem_q)
                                                               : BEAT_WIDTH'(MAX_BURST_LENGTH);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = (r_len == '0) ? StDrain : StAddr;
            StAddr:  if (ar_fire) state_d = StData;
            StData:  if (r_fire && last_beat) state_d = (rem_q != '0) ? StAddr : StDrain;
            StDrain: if (t_fire) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        r_ready      = (state_q == StIdle);
        src.ar_valid = (state_q == StAddr);
        src.r_ready  = (state_q == StData) && (!t_valid_q || dest.t_ready);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q    <= '0;
            rem_q     <= '0;
            beats_q   <= '0;
            t_data_q  <= '0;
            t_valid_q <= 1'b0;
            t_last_q  <= 1'b0;
            t_null_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (t_fire) t_valid_q <= 1'b0;
            if (accept) begin
                addr_q <= r_src & ALIGN_MASK;
                rem_q  <= r_len;
                err_q  <= 1'b0;
                if (r_len == '0) begin
                    t_data_q  <= '0;
                    t_valid_q <= 1'b1;
                    t_last_q  <= 1'b1;
                    t_null_q  <= 1'b1;
                end
            end
            if (ar_fire) begin
                addr_q  <= addr_q + (ADDR_WIDTH'(burst_n) << ADDR_SHIFT);
                rem_q   <= rem_q - LEN_WIDTH'(burst_n);
                beats_q <= burst_n;
            end
            if (r_fire) begin
                t_data_q  <= src.r_data;
                t_valid_q <= 1'b1;
                t_last_q  <= last_beat && (rem_q == '0);
                t_null_q  <= 1'b0;
                beats_q   <= beats_q - BEAT_WIDTH'(1);
                if (src.r_resp != 2'b00) err_q <= 1'b1;
            end
        end
    end

    assign r_err = err_q;

    assign src.ar_id     = '0;
    assign src.ar_addr   = addr_q;
    assign src.ar_len    = 8'(burst_n - BEAT_WIDTH'(1));
    assign src.ar_size   = 3'(ADDR_SHIFT);
    assign src.ar_burst  = 2'b01;
    assign src.ar_lock   = 1'b0;
    assign src.ar_cache  = '0;
    assign src.ar_prot   = '0;
    assign src.ar_qos    = '0;
    assign src.ar_region = '0;
    assign src.ar_user   = '0;

    assign src.aw_id     = '0;
    assign src.aw_addr   = '0;
    assign src.aw_len    = '0;
    assign src.aw_size   = '0;
    assign src.aw_burst  = '0;
    assign src.aw_lock   = 1'b0;
    assign src.aw_cache  = '0;
    assign src.aw_prot   = '0;
    assign src.aw_qos    = '0;
    assign src.aw_region = '0;
    assign src.aw_user   = '0;
    assign src.aw_valid  = 1'b0;
    assign src.w_data    = '0;
    assign src.w_strb    = '0;
    assign src.w_last    = 1'b0;
    assign src.w_user    = '0;
    assign src.w_valid   = 1'b0;
    assign src.b_ready   = 1'b0;

    assign dest.t_valid = t_valid_q;
    assign dest.t_data  = t_data_q;
    assign dest.t_last  = t_last_q;
    assign dest.t_strb  = t_null_q ? '0 : '1;
    assign dest.t_keep  = t_null_q ? '0 : '1;
    assign dest.t_id    = '0;
    assign dest.t_dest  = '0;
    assign dest.t_user  = '0;

    logic unused_inputs;
    assign unused_inputs = ^{src.aw_ready, src.w_ready, src.b_id, src.b_resp, src.b_user,
                             src.b_valid, src.r_id, src.r_user};

`ifndef SYNTHESIS
    always_ff @(posedge aclk) begin
        if (aresetn && accept) begin
            assert ((r_src & ~ALIGN_MASK) == '0) else $error("misaligned r_src");
        end
        if (aresetn && r_fire) begin
            assert (src.r_last == last_beat) else $error("r_last disagrees with beat count");
        end
    end
`endif

endmodule
